// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types, default vectors and alignment helper for the fetch program counter
// Optional feature macro used by importers: PC_RAS_EN (return-address stack).
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'd100;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h180;

    // Widest address the alignment helper accepts; callers zero-extend into it.
    localparam int unsigned PC_MAX_W = 64;

    // True when addr is a multiple of inst_bytes (inst_bytes must be a power of two).
    function automatic logic align_ok(input logic [PC_MAX_W-1:0] addr,
                                      input int unsigned         inst_bytes);
        logic [PC_MAX_W-1:0] mask;
        mask = PC_MAX_W'(inst_bytes) - PC_MAX_W'(1);
        return (addr & mask) == '0;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with push, pop, replace and flush
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   push, pop, flush    stack operations (push+pop on a non-empty stack replaces the top)
//   push_data           return address written on push / replace
//   top                 current top-of-stack entry
//   empty, full         occupancy flags
module pc_ras #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned PC_WIDTH  = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] push_data,
    output logic [PC_WIDTH-1:0] top,
    output logic                empty,
    output logic                full
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_inc;
    logic [PTR_W-1:0]    ptr_dec;
    logic [CNT_W-1:0]    count;
    logic                do_replace;
    logic                do_push;
    logic                do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(RAS_DEPTH));
    assign top   = mem[ptr];

    // Pointer wraps explicitly so non-power-of-two depths stay circular.
    assign ptr_inc = (ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign ptr_dec = (ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr - 1'b1;

    assign do_replace = push && pop && !empty;
    assign do_push    = push && !do_replace;
    assign do_pop     = pop && !push && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (do_push) begin
            // When full the pointer still advances, overwriting the oldest entry.
            ptr <= ptr_inc;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (do_pop) begin
            ptr   <= ptr_dec;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!flush) begin
            if (do_replace) begin
                mem[ptr] <= push_data;
            end else if (do_push) begin
                mem[ptr_inc] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with redirect, trap/eret and optional return-address stack
// Optional feature: define PC_RAS_EN to build the return-address stack.
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   stall               hold pc
//   redirect_valid/_target  resolved taken branch/jump; misaligned target traps
//   eret                return from trap to epc
//   ras_push, ras_pop   predicted call/return at current pc (stack builds only)
//   pc, pc_plus         fetch address and pc + INST_BYTES
//   fetch_valid         pc is a real fetch
//   in_trap             executing in the trap handler
//   epc                 misaligned target captured on trap entry
//   ras_underflow       one-cycle pulse on pop of an empty stack
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned         INST_BYTES   = 4,
    parameter int unsigned         RAS_DEPTH    = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                eret,
    input  logic                ras_push,
    input  logic                ras_pop,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus,
    output logic                fetch_valid,
    output logic                in_trap,
    output logic [PC_WIDTH-1:0] epc,
    output logic                ras_underflow
);

    pc_state_e           state;
    pc_state_e           state_n;
    logic [PC_WIDTH-1:0] pc_n;
    logic [PC_WIDTH-1:0] epc_n;
    logic                underflow_n;
    logic                target_aligned;
    logic                ras_push_en;
    logic                ras_pop_en;
    logic                ras_flush;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_empty;

    assign pc_plus        = pc + PC_WIDTH'(INST_BYTES);
    assign target_aligned = align_ok(PC_MAX_W'(redirect_target), INST_BYTES);

`ifdef PC_RAS_EN
    logic ras_full;
    logic unused_ras_full;

    assign unused_ras_full = ras_full;

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_WIDTH  (PC_WIDTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (ras_push_en),
        .pop       (ras_pop_en),
        .flush     (ras_flush),
        .push_data (pc_plus),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ras_inputs;

    assign unused_ras_inputs = &{1'b0, ras_push, ras_pop, ras_push_en, ras_pop_en, ras_flush};
    assign ras_top           = '0;
    assign ras_empty         = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            epc           <= '0;
            fetch_valid   <= 1'b0;
            in_trap       <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            epc           <= epc_n;
            fetch_valid   <= (state_n != BOOT);
            in_trap       <= (state_n == TRAP);
            ras_underflow <= underflow_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        epc_n       = epc;
        underflow_n = 1'b0;
        ras_push_en = 1'b0;
        ras_pop_en  = 1'b0;
        ras_flush   = 1'b0;

        case (state)
            BOOT: begin
                // First fetch is the reset vector itself, so pc does not move here.
                state_n = RUN;
            end
            RUN, TRAP: begin
                if (redirect_valid) begin
                    ras_flush = 1'b1;
                    if (!target_aligned) begin
                        epc_n   = redirect_target;
                        pc_n    = TRAP_VECTOR;
                        state_n = TRAP;
                    end else begin
                        pc_n = redirect_target;
                    end
                end else if (eret && (state == TRAP)) begin
                    pc_n    = epc;
                    state_n = RUN;
                end else if (stall) begin
                    pc_n = pc;
                end else begin
                    pc_n = pc_plus;
`ifdef PC_RAS_EN
                    ras_push_en = ras_push;
                    if (ras_pop) begin
                        if (ras_empty) begin
                            underflow_n = 1'b1;
                        end else begin
                            pc_n       = ras_top;
                            ras_pop_en = 1'b1;
                        end
                    end
`endif
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven self-checking bench for pc_gen
module tb_pc_gen;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        eret;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic        in_trap;
    logic [31:0] epc;
    logic        ras_underflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic        eret;
        logic [31:0] exp_pc;
        logic        exp_trap;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[$];

    pc_gen dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .eret            (eret),
        .ras_push        (ras_push),
        .ras_pop         (ras_pop),
        .pc              (pc),
        .pc_plus         (pc_plus),
        .fetch_valid     (fetch_valid),
        .in_trap         (in_trap),
        .epc             (epc),
        .ras_underflow   (ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic rv, input logic [31:0] tgt, input logic er,
                       input logic [31:0] epc_v, input logic trap, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.rv = rv; v.tgt = tgt; v.eret = er;
        v.exp_pc = epc_v; v.exp_trap = trap; v.exp_epc = ep;
        vecs.push_back(v);
    endtask

    // Drive inputs, let one rising edge pass, sample at the following falling edge.
    task automatic step(input logic s, input logic rv, input logic [31:0] tgt, input logic er,
                        input logic push, input logic pop);
        stall = s; redirect_valid = rv; redirect_target = tgt; eret = er;
        ras_push = push; ras_pop = pop;
        @(posedge clock);
        @(negedge clock);
        stall = 0; redirect_valid = 0; eret = 0; ras_push = 0; ras_pop = 0;
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp_pc, input logic exp_uf);
        chk({name, ".pc"}, pc, exp_pc);
        chk({name, ".uf"}, {31'd0, ras_underflow}, {31'd0, exp_uf});
    endtask

    initial begin
        reset_n = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
        eret = 0; ras_push = 0; ras_pop = 0;

        //   stall rv  target        eret  exp_pc        trap epc
        add(0, 0, 32'h0,         0, 32'd100,       0, 32'h0);
        add(0, 0, 32'h0,         0, 32'd104,       0, 32'h0);
        add(0, 0, 32'h0,         0, 32'd108,       0, 32'h0);
        add(1, 0, 32'h0,         0, 32'd108,       0, 32'h0);
        add(1, 0, 32'h0,         0, 32'd108,       0, 32'h0);
        add(0, 0, 32'h0,         0, 32'd112,       0, 32'h0);
        add(1, 1, 32'h200,       0, 32'h200,       0, 32'h0);
        add(0, 0, 32'h0,         0, 32'h204,       0, 32'h0);
        add(0, 1, 32'h202,       0, 32'h180,       1, 32'h202);
        add(0, 0, 32'h0,         0, 32'h184,       1, 32'h202);
        add(1, 0, 32'h0,         0, 32'h184,       1, 32'h202);
        add(1, 0, 32'h0,         1, 32'h202,       0, 32'h202);
        add(0, 1, 32'h300,       0, 32'h300,       0, 32'h202);
        add(0, 0, 32'h0,         1, 32'h304,       0, 32'h202);
        add(0, 1, 32'h301,       0, 32'h180,       1, 32'h301);
        add(0, 1, 32'h400,       0, 32'h400,       1, 32'h301);
        add(0, 1, 32'h402,       0, 32'h180,       1, 32'h402);
        add(0, 0, 32'h0,         1, 32'h402,       0, 32'h402);
        add(0, 1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 0, 32'h402);
        add(0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'h402);
        add(0, 0, 32'h0,         0, 32'h0,         0, 32'h402);

        repeat (2) @(negedge clock);
        chk("rst.pc",  pc, 32'd100);
        chk("rst.fv",  {31'd0, fetch_valid}, 32'd0);
        chk("rst.trap", {31'd0, in_trap}, 32'd0);
        chk("rst.epc", epc, 32'd0);
        chk("rst.uf",  {31'd0, ras_underflow}, 32'd0);
        reset_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].stall, vecs[i].rv, vecs[i].tgt, vecs[i].eret, 0, 0);
            chk($sformatf("v%0d.pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d.pc_plus", i), pc_plus, vecs[i].exp_pc + 32'd4);
            chk($sformatf("v%0d.fv", i), {31'd0, fetch_valid}, 32'd1);
            chk($sformatf("v%0d.trap", i), {31'd0, in_trap}, {31'd0, vecs[i].exp_trap});
            chk($sformatf("v%0d.epc", i), epc, vecs[i].exp_epc);
            chk($sformatf("v%0d.uf", i), {31'd0, ras_underflow}, 32'd0);
        end

        // Asynchronous reset in the middle of a trap, checked before the next rising edge.
        step(0, 1, 32'h206, 0, 0, 0);
        chk("pretrap.trap", {31'd0, in_trap}, 32'd1);
        #2 reset_n = 0;
        #1;
        chk("arst.pc",   pc, 32'd100);
        chk("arst.trap", {31'd0, in_trap}, 32'd0);
        chk("arst.fv",   {31'd0, fetch_valid}, 32'd0);
        chk("arst.epc",  epc, 32'd0);
        @(negedge clock);
        reset_n = 1;
        step(0, 0, 0, 0, 0, 0);
        chk("reboot.pc", pc, 32'd100);
        chk("reboot.fv", {31'd0, fetch_valid}, 32'd1);

`ifdef PC_RAS_EN
        step(0, 1, 32'h40, 0, 0, 0);  chk_pc("r0", 32'h40, 0);
        step(0, 0, 0, 0, 1, 0);       chk_pc("r1", 32'h44, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("r2", 32'h44, 0);
        step(0, 0, 0, 0, 0, 0);       chk_pc("r3", 32'h48, 0);

        step(0, 1, 32'h1000, 0, 0, 0); chk_pc("o0", 32'h1000, 0);
        step(0, 0, 0, 0, 1, 0);       chk_pc("o1", 32'h1004, 0);
        step(0, 0, 0, 0, 1, 0);       chk_pc("o2", 32'h1008, 0);
        step(0, 0, 0, 0, 1, 0);       chk_pc("o3", 32'h100C, 0);
        step(0, 0, 0, 0, 1, 0);       chk_pc("o4", 32'h1010, 0);
        step(0, 0, 0, 0, 1, 0);       chk_pc("o5", 32'h1014, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("p1", 32'h1014, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("p2", 32'h1010, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("p3", 32'h100C, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("p4", 32'h1008, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("p5", 32'h100C, 1);
        step(0, 0, 0, 0, 0, 0);       chk_pc("p6", 32'h1010, 0);

        step(0, 1, 32'h2000, 0, 0, 0); chk_pc("x0", 32'h2000, 0);
        step(0, 0, 0, 0, 1, 0);       chk_pc("x1", 32'h2004, 0);
        step(0, 0, 0, 0, 1, 1);       chk_pc("x2", 32'h2004, 0);
        step(1, 0, 0, 0, 0, 1);       chk_pc("x3", 32'h2004, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("x4", 32'h2008, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("x5", 32'h200C, 1);
`else
        step(0, 0, 0, 0, 1, 1);       chk_pc("nras0", 32'd104, 0);
        step(0, 0, 0, 0, 0, 1);       chk_pc("nras1", 32'd108, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
